// File: rtl/weight_buffer_pp.sv
// weight_buffer_pp: ping-pong weight buffer, one bank fills while the other is drained by address.
module weight_buffer_pp #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH = 8192,
    parameter int OFF_SET_SHIFT = 2
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  wr_en,
    input  logic [DATA_WIDTH-1:0]                 wr_data,
    input  logic                                  wr_last,
    output logic                                  wr_ready,
    input  logic                                  rd_en,
    input  logic [$clog2(DEPTH)+OFF_SET_SHIFT-1:0] rd_addr,
    input  logic                                  rd_done,
    output logic                                  rd_ready,
    output logic [DATA_WIDTH-1:0]                 data_out,
    output logic                                  data_valid,
    output logic [$clog2(DEPTH):0]                fill_len
);
    localparam int AW = $clog2(DEPTH);
    typedef enum logic [1:0] {EMPTY, FILLING, FULL} state_t;
    state_t st [2];
    state_t st_nxt [2];
    logic [AW:0] len [2];
    logic wr_bank, rd_bank;
    logic [AW-1:0] wr_ptr, rd_idx;
    logic [DATA_WIDTH-1:0] mem0 [DEPTH];
    logic [DATA_WIDTH-1:0] mem1 [DEPTH];
    logic wr_acc, wr_fin, rd_acc, rel, unused_addr;
    always_comb begin
        wr_ready = st[wr_bank] != FULL;
        rd_ready = st[rd_bank] == FULL;
        fill_len = rd_ready ? len[rd_bank] : '0;
        wr_acc = wr_en && wr_ready && !rst;
        wr_fin = wr_acc && (wr_last || wr_ptr == AW'(DEPTH - 1));
        rd_acc = rd_en && rd_ready && !rst;
        rel = rd_done && rd_ready && !rst;
        rd_idx = rd_addr[AW+OFF_SET_SHIFT-1:OFF_SET_SHIFT];
        unused_addr = ^rd_addr;
    end
    // A releasing bank is always FULL and so never the bank being written.
    always_comb begin
        st_nxt = st;
        if (wr_acc) st_nxt[wr_bank] = wr_fin ? FULL : FILLING;
        if (rel) st_nxt[rd_bank] = EMPTY;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            st[0] <= EMPTY;
            st[1] <= EMPTY;
            wr_bank <= 1'b0;
            rd_bank <= 1'b0;
            wr_ptr <= '0;
        end else begin
            st <= st_nxt;
            if (wr_acc) wr_ptr <= wr_fin ? '0 : wr_ptr + 1'b1;
            if (wr_fin) len[wr_bank] <= {1'b0, wr_ptr} + 1'b1;
            if (wr_fin) wr_bank <= ~wr_bank;
            if (rel) rd_bank <= ~rd_bank;
        end
    end
    always_ff @(posedge clk) begin
        if (wr_acc && !wr_bank) mem0[wr_ptr] <= wr_data;
        if (wr_acc && wr_bank) mem1[wr_ptr] <= wr_data;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            data_out <= '0;
            data_valid <= 1'b0;
        end else begin
            data_valid <= rd_acc;
            if (rd_acc) data_out <= rd_bank ? mem1[rd_idx] : mem0[rd_idx];
        end
    end
endmodule

// File: tb/tb_weight_buffer_pp.sv
// tb_weight_buffer_pp: scoreboard bench for the ping-pong weight buffer.
module tb_weight_buffer_pp;
    logic clk = 0, rst = 1;
    logic wr_en = 0, wr_last = 0, rd_en = 0, rd_done = 0;
    logic [31:0] wr_data = 0;
    logic [4:0] rd_addr = 0;
    logic wr_ready, rd_ready, data_valid;
    logic [31:0] data_out;
    logic [3:0] fill_len;
    int total = 0, bad = 0;
    logic [31:0] q [$];

    weight_buffer_pp #(.DATA_WIDTH(32), .DEPTH(8), .OFF_SET_SHIFT(2)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .wr_last(wr_last),
        .wr_ready(wr_ready), .rd_en(rd_en), .rd_addr(rd_addr), .rd_done(rd_done),
        .rd_ready(rd_ready), .data_out(data_out), .data_valid(data_valid), .fill_len(fill_len)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] d, input logic last);
        wr_en = 1;
        wr_data = d;
        wr_last = last;
        tick;
        wr_en = 0;
        wr_last = 0;
    endtask

    task automatic rd(input logic [4:0] a, input logic [31:0] exp);
        rd_en = 1;
        rd_addr = a;
        q.push_back(exp);
        tick;
        rd_en = 0;
    endtask

    task automatic release_bank;
        rd_done = 1;
        tick;
        rd_done = 0;
    endtask

    task automatic do_reset;
        rst = 1;
        tick;
        rst = 0;
    endtask

    task automatic flags(input string tag, input logic wr_r, input logic rd_r, input logic [3:0] len);
        chk({tag, "_wr_ready"}, 32'(wr_ready), 32'(wr_r));
        chk({tag, "_rd_ready"}, 32'(rd_ready), 32'(rd_r));
        chk({tag, "_fill_len"}, 32'(fill_len), 32'(len));
    endtask

    always @(posedge clk) begin
        #2;
        if (data_valid) begin
            if (q.size() == 0) chk("unexpected_valid", 32'(data_valid), 0);
            else chk("rdata", data_out, q.pop_front());
        end
    end

    initial begin
        tick;
        do_reset;
        flags("reset", 1, 0, 0);
        chk("reset_data_out", data_out, 0);
        chk("reset_valid", 32'(data_valid), 0);

        // four-word fill closed by wr_last
        wr(32'hA0, 0);
        flags("partial", 1, 0, 0);
        wr(32'hA1, 0);
        wr(32'hA2, 0);
        wr(32'hA3, 1);
        flags("fill4", 1, 1, 4);
        rd(5'h0C, 32'hA3);
        rd(5'h01, 32'hA0);
        release_bank;
        flags("released", 1, 0, 0);

        // eight words fill bank 0 without wr_last; ninth goes to bank 1
        do_reset;
        for (int i = 0; i < 8; i++) wr(32'hB0 + i, 0);
        flags("fill8", 1, 1, 8);
        wr(32'hC0, 1);
        flags("both_full", 0, 1, 8);
        rd(5'h1C, 32'hB7);
        rd(5'h00, 32'hB0);
        release_bank;
        flags("bank1", 1, 1, 1);
        rd(5'h00, 32'hC0);

        // memory survives reset; reads beyond fill_len return stale words
        do_reset;
        for (int i = 0; i < 3; i++) wr(32'hD0 + i, i == 2);
        rd(5'h14, 32'hB5);
        for (int i = 0; i < 3; i++) wr(32'hE0 + i, i == 2);
        flags("full2", 0, 1, 3);
        wr(32'hF0, 1);
        flags("dropped", 0, 1, 3);
        release_bank;
        flags("after_done", 1, 1, 3);
        rd(5'h00, 32'hE0);
        rd(5'h08, 32'hE2);
        wr(32'h60, 0);
        wr(32'h61, 1);
        release_bank;
        flags("g_fill", 1, 1, 2);
        rd(5'h00, 32'h60);

        // read and release in the same cycle
        rd_en = 1;
        rd_done = 1;
        rd_addr = 5'h05;
        q.push_back(32'h61);
        tick;
        rd_en = 0;
        rd_done = 0;
        flags("rd_and_done", 1, 0, 0);
        wr(32'h70, 1);
        flags("bank1_next", 1, 1, 1);
        rd(5'h00, 32'h70);

        // completing write and release together on different banks
        wr_en = 1;
        wr_data = 32'h80;
        wr_last = 1;
        rd_done = 1;
        tick;
        wr_en = 0;
        wr_last = 0;
        rd_done = 0;
        flags("wr_and_done", 1, 1, 1);
        rd(5'h00, 32'h80);
        release_bank;
        flags("empty", 1, 0, 0);

        // read while not ready: no valid, data held
        rd_en = 1;
        rd_addr = 0;
        tick;
        rd_en = 0;
        chk("idle_valid", 32'(data_valid), 0);
        chk("idle_hold", data_out, 32'h80);

        // reset mid-fill discards the fill
        wr(32'h90, 0);
        wr(32'h91, 0);
        do_reset;
        flags("midfill_rst", 1, 0, 0);
        chk("midfill_data_out", data_out, 0);
        chk("midfill_valid", 32'(data_valid), 0);
        wr(32'hC5, 1);
        flags("restart", 1, 1, 1);
        rd(5'h00, 32'hC5);
        tick;
        tick;
        chk("scoreboard_empty", 32'(q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/weight_buffer_pp.md
WEIGHT_BUFFER_PP -- requirements
Module: weight_buffer_pp

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, bits per word.
REQ-002 SHALL have parameter DEPTH, default 8192, words per bank; power of two, at least 2.
REQ-003 SHALL have parameter OFF_SET_SHIFT, default 2, right-shift from byte read address to word index.
REQ-004 SHALL have port clk, input, 1, sole clock; all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-006 SHALL have port wr_en, input, 1, write strobe into current fill bank.
REQ-007 SHALL have port wr_data, input, DATA_WIDTH, write word.
REQ-008 SHALL have port wr_last, input, 1, qualified by wr_en; marks the final word of a fill.
REQ-009 SHALL have port wr_ready, output, 1, fill bank is EMPTY or FILLING.
REQ-010 SHALL have port rd_en, input, 1, read strobe from current drain bank.
REQ-011 SHALL have port rd_addr, input, $clog2(DEPTH)+OFF_SET_SHIFT, byte address.
REQ-012 SHALL have port rd_done, input, 1, releases the drain bank.
REQ-013 SHALL have port rd_ready, output, 1, drain bank is FULL.
REQ-014 SHALL have port data_out, output, DATA_WIDTH, registered read data.
REQ-015 SHALL have port data_valid, output, 1, data_out updated this cycle.
REQ-016 SHALL have port fill_len, output, $clog2(DEPTH)+1, word count of the drain bank; 0 when not rd_ready.

Function
REQ-017 SHALL hold two banks (0, 1) of DEPTH x DATA_WIDTH, block-RAM style, each with state EMPTY, FILLING or FULL.
REQ-018 SHALL keep wr_bank and rd_bank pointers; fills go to wr_bank, reads come from rd_bank.
REQ-019 Accepted write (wr_en and wr_ready) SHALL store wr_data at internal wr_ptr, increment wr_ptr, and move the bank EMPTY to FILLING.
REQ-020 Accepted write with wr_last, or with wr_ptr = DEPTH-1, SHALL mark the bank FULL, latch its length (wr_ptr+1), clear wr_ptr and toggle wr_bank.
REQ-021 wr_en while wr_ready=0 SHALL be ignored: no memory write, no pointer change.
REQ-022 Accepted read (rd_en and rd_ready) SHALL give data_out = bank[rd_addr >> OFF_SET_SHIFT] and data_valid=1 on the next edge (latency 1).
REQ-023 Low OFF_SET_SHIFT address bits SHALL be ignored.
REQ-024 rd_en while rd_ready=0 SHALL leave data_out unchanged and drive data_valid=0.
REQ-025 Reads at word index >= fill_len SHALL return stale bank contents with no error flag.
REQ-026 rd_done while rd_ready=1 SHALL mark rd_bank EMPTY and toggle rd_bank; ignored otherwise.
REQ-027 rd_en and rd_done in the same cycle SHALL complete the read from the old bank before release.
REQ-028 A completing write and rd_done in the same cycle on different banks SHALL both take effect.
REQ-029 Both banks FULL SHALL drive wr_ready=0 until rd_done.
REQ-030 A bank SHALL become readable on the cycle after its FULL transition; no write-to-read bypass.
REQ-031 wr_ready, rd_ready and fill_len SHALL be decoded from registered state only, with no combinational path from inputs.

Reset
REQ-032 On rst=1 at a clock edge: both banks EMPTY; wr_bank=0, rd_bank=0, wr_ptr=0; data_out=0, data_valid=0; hence wr_ready=1, rd_ready=0, fill_len=0.
REQ-033 Reset SHALL NOT clear memory contents.
REQ-034 Reset SHALL take priority over all same-cycle inputs; a fill or drain in progress is discarded.

Verification (DATA_WIDTH=32, DEPTH=8, OFF_SET_SHIFT=2)
REQ-035 Write 0xA0..0xA3, wr_last on 0xA3 -> rd_ready=1 next cycle, fill_len=4; rd_addr=0x0C -> data_out=0xA3, data_valid=1 one cycle later.
REQ-036 Write 8 words with no wr_last -> bank 0 FULL, fill_len=8; 9th wr_en lands in bank 1 at word 0.
REQ-037 Fill both banks (3 words each) -> wr_ready=0; a 7th wr_en is dropped; rd_done -> wr_ready=1, rd_ready=1, fill_len=3 (bank 1).
REQ-038 rd_en with rd_addr=0x05 and rd_done in the same cycle -> data_out = bank0[1]; next cycle rd_bank=1.
REQ-039 rst asserted mid-fill after 2 words -> all outputs at reset values; next fill restarts at bank 0, word 0.
REQ-040 rd_en while rd_ready=0 -> data_valid=0 and data_out holds its previous value.
